fc_vector_relay: RTL and testbench
==================================

# fc_vector_relay

Receiving end of the FC-layer output stream. Accepts the VEC_LEN results an `fc_*` layer emits on its output_valid/output_ready port and stores them in a two-bank (ping-pong) register buffer. Replays each completed vector, element 0 first, on an input-style valid/ready stream for the next layer's input_valid/input_ready/input_data port. Sits between consecutive layers in multi-layer accelerator builds, so a producer layer never stalls on a consumer that is still computing.

## Interface

**Parameters**
- WIDTH, 16: signed element width, Q-format passthrough with no arithmetic.
- VEC_LEN, 8: elements per vector; must equal the producer's M and the consumer's N; must be ≥ 2.

**Ports**
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: producer element valid.
- in_ready, output, 1: relay can accept an element.
- in_data, input, WIDTH (signed): producer element.
- out_valid, output, 1: element available to the consumer.
- out_ready, input, 1: consumer accepts the element.
- out_data, output, WIDTH (signed): element to the consumer.
- out_last, output, 1: out_data is element VEC_LEN-1 of its vector.

## Operation

- **Handshake.** A transfer occurs on a rising clk edge where valid && ready. No other condition causes a transfer.
- **Storage.** Two banks, each VEC_LEN x WIDTH registers.
- **Per-bank state.** Each bank has a full flag.
- **Write side.** Write pointer wr_bank (1 bit) plus wr_idx (0..VEC_LEN-1).
  - Every input transfer writes in_data to bank[wr_bank][wr_idx].
  - wr_idx then increments.
  - When wr_idx == VEC_LEN-1 on a transfer: full[wr_bank] is set, wr_idx wraps to 0, and wr_bank toggles.
- **Read side.** Read pointer rd_bank plus rd_idx, handled symmetrically.
  - out_data is bank[rd_bank][rd_idx] while full[rd_bank].
  - On an output transfer, rd_idx increments.
  - When rd_idx == VEC_LEN-1 on a transfer: full[rd_bank] is cleared, rd_idx wraps to 0, and rd_bank toggles.
- **Output signals (combinational from registered state only).**
  - in_ready = !reset && !full[wr_bank].
  - out_valid = !reset && full[rd_bank].
  - out_last = out_valid && rd_idx == VEC_LEN-1.
  - out_data = 0 when out_valid is low.
- **No combinational paths.** There is no in_valid→in_ready, out_ready→in_ready, or in_valid→out_valid combinational path.
- **Empty.** Both full flags clear: out_valid=0 and in_ready=1.
- **Full.** Both flags set: in_ready=0. in_ready rises the cycle after the last element of rd_bank is transferred out.
- **Simultaneous events.** Completing a write into one bank and completing a read of the other bank on the same edge is legal. Both flag updates take effect, and no element is lost or duplicated.
- **Partial vectors.** Elements stay buffered until the vector is complete; there is no timeout and no flush.
- **Data integrity.** Data passes bit-exact, including negative values and saturated values 32767/-32768.

## Timing

- **Reset.** On any clk edge with reset=1, all pointers and full flags clear.
  - While reset is high: in_ready=0, out_valid=0, out_last=0, out_data=0.
  - Bank contents are don't-care.
  - Mid-operation reset discards all buffered data. in_ready=1 on the first cycle with reset low.
- **Latency.** The last input transfer of a vector at edge k gives out_valid=1 with element 0 in the cycle after edge k (1-cycle fill latency).
- **Throughput.** 1 element per cycle sustained on both sides when out_ready is held high and the producer streams continuously. Both sides operate concurrently on different banks.
- **Output stability.** While out_valid=1 and out_ready=0, out_data and out_last hold stable.

## Structure

- **Shared package `fc_stream_pkg`:**
  - WIDTH default constant.
  - typedef `elem_t` (logic signed [WIDTH-1:0]).
  - typedef `ptr_t` for the bank/index pair.
  - This package is also used by the FC generator output.
- **Sub-module `vec_bank`:** one VEC_LEN x WIDTH register bank with write enable/index and combinational read index. It is instantiated twice.
- **Top-level contents:** pointers, full flags and handshake logic. Expected size is roughly 150–250 lines.

## Test plan

1. **Reset behaviour.** Assert reset for 2 cycles, then release → in_ready=0 and out_valid=0 during reset; in_ready=1 and out_valid=0 after release.
2. **Single vector.** Stream 1..8 with out_ready=0 → out_valid=1 one cycle after the 8th transfer. Raise out_ready → 1..8 appear on consecutive cycles, with out_last only on 8.
3. **Full condition.** Send 16 elements (two vectors) with out_ready=0 → in_ready=0 after the 16th transfer. The 17th in_valid is not accepted.
4. **Full release.** Read 8 elements from the full state of test 3 → in_ready returns to 1 the cycle after the 8th output transfer. Output order is 1..8, then 9..16.
5. **Concurrent streaming.** Drive both sides continuously with random valid/ready, using values including -32768, 32767, -1 and 0, over 20 vectors → the scoreboard shows bit-exact, in-order data; out_last on every 8th element; no loss.
6. **Reset mid-operation.** Assert reset after 5 elements of vector 2 while vector 1 is half read → after release, out_valid=0. A fresh vector 100..107 replays exactly as 100..107.

Source files
------------

// File: rtl/fc_stream_pkg.sv
// Shared stream types for FC layer output/input ports.
// Used by the relay buffer and the FC generator output stage.
package fc_stream_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int VEC_LEN_DEF = 8;
    localparam int IDX_W       = 8;

    typedef logic signed [WIDTH_DEF-1:0] elem_t;

    typedef struct packed {
        logic             bank;
        logic [IDX_W-1:0] idx;
    } ptr_t;

    // Step a bank/index pointer; wraps and flips bank after the last slot.
    function automatic ptr_t ptr_adv(
        input ptr_t             p,
        input logic [IDX_W-1:0] last
    );
        ptr_t n;
        if (p.idx == last) begin
            n.bank = ~p.bank;
            n.idx  = '0;
        end else begin
            n.bank = p.bank;
            n.idx  = p.idx + IDX_W'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/vec_bank.sv
// One VEC_LEN x WIDTH register bank: indexed write, combinational read.
// Contents are not reset; the relay's full flags qualify the data.
module vec_bank #(
    parameter int WIDTH   = 16,
    parameter int VEC_LEN = 8,
    parameter int IW      = $clog2(VEC_LEN)
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [IW-1:0]           widx_i,
    input  logic signed [WIDTH-1:0] wdata_i,
    input  logic [IW-1:0]           ridx_i,
    output logic signed [WIDTH-1:0] rdata_o
);

    logic signed [WIDTH-1:0] mem_q [VEC_LEN];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/fc_vector_relay.sv
// Ping-pong vector relay between an FC layer's output stream and the
// next layer's input stream; replays each complete vector in order.
module fc_vector_relay
    import fc_stream_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int VEC_LEN = VEC_LEN_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_last
);

    localparam int IW = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(VEC_LEN - 1);

    ptr_t       wr_q, wr_d;
    ptr_t       rd_q, rd_d;
    logic [1:0] full_q, full_d;
    logic       wr_fire, rd_fire;

    logic signed [WIDTH-1:0] rdata [2];

    // Handshake outputs depend only on registered state and reset.
    assign in_ready  = !reset && !full_q[wr_q.bank];
    assign out_valid = !reset && full_q[rd_q.bank];
    assign out_last  = out_valid && (rd_q.idx == LAST);
    assign out_data  = out_valid ? rdata[rd_q.bank] : '0;

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;

    // Write and read always target different banks, so both flag
    // updates can land on the same edge.
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        full_d = full_q;
        if (wr_fire) begin
            wr_d = ptr_adv(wr_q, LAST);
            if (wr_q.idx == LAST) begin
                full_d[wr_q.bank] = 1'b1;
            end
        end
        if (rd_fire) begin
            rd_d = ptr_adv(rd_q, LAST);
            if (rd_q.idx == LAST) begin
                full_d[rd_q.bank] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= '0;
            rd_q   <= '0;
            full_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            full_q <= full_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        vec_bank #(
            .WIDTH   (WIDTH),
            .VEC_LEN (VEC_LEN),
            .IW      (IW)
        ) u_bank (
            .clk     (clk),
            .we_i    (wr_fire && (wr_q.bank == 1'(b))),
            .widx_i  (wr_q.idx[IW-1:0]),
            .wdata_i (in_data),
            .ridx_i  (rd_q.idx[IW-1:0]),
            .rdata_o (rdata[b])
        );
    end

endmodule

// File: tb/tb_fc_vector_relay.sv
// Scoreboard bench for fc_vector_relay: accepted inputs are queued,
// a negedge monitor pops and compares every output transfer.
module tb_fc_vector_relay;
    import fc_stream_pkg::*;

    localparam int VL = 8;

    logic  clk       = 1'b0;
    logic  reset     = 1'b1;
    logic  in_valid  = 1'b0;
    logic  out_ready = 1'b0;
    elem_t in_data   = '0;
    logic  in_ready, out_valid, out_last;
    elem_t out_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        elem_t d;
        logic  last;
    } exp_t;

    exp_t  exp_q[$];
    int    in_cnt   = 0;
    int    out_cnt  = 0;
    int    last_cnt = 0;
    logic  hold_v   = 1'b0;
    elem_t hold_d   = '0;
    logic  hold_l   = 1'b0;
    bit    prod_done;
    int    cyc;
    int    base_out, base_last;

    elem_t tbl [8] = '{
        -16'sd32768, 16'sd32767, -16'sd1, 16'sd0,
        16'sd1, -16'sd2, 16'sd12345, -16'sd12345
    };

    always #5 clk = ~clk;

    fc_vector_relay #(
        .WIDTH   (16),
        .VEC_LEN (VL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: transfers decided at the next posedge are sampled here.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            exp_q.delete();
            in_cnt = 0;
            hold_v = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back('{in_data, logic'(in_cnt == VL - 1)});
                in_cnt = (in_cnt + 1) % VL;
            end
            if (hold_v) begin
                chk("hold_data", out_data, hold_d);
                chk("hold_last", out_last, hold_l);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.last);
                end
                out_cnt++;
                if (out_last) last_cnt++;
                hold_v = 1'b0;
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_d = out_data;
                hold_l = out_last;
            end else begin
                hold_v = 1'b0;
                chk("idle_data", out_data, 0);
                chk("idle_last", out_last, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input elem_t v);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic drain(input bit rnd, output int n);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset behaviour
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        tick();

        // Single vector, 1-cycle fill latency, 8 consecutive outputs
        for (int i = 1; i <= 7; i++) send(elem_t'(i));
        chk("partial_out_valid", out_valid, 0);
        send(elem_t'(8));
        chk("fill_out_valid", out_valid, 1);
        chk("fill_out_data", out_data, 1);
        chk("fill_out_last", out_last, 0);
        drain(1'b0, cyc);
        chk("single_drain_cycles", cyc, 8);
        chk("single_empty_valid", out_valid, 0);

        // Full condition
        for (int i = 1; i <= 16; i++) send(elem_t'(i));
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_data  = elem_t'(17);
        repeat (3) begin
            @(negedge clk);
            chk("full_no_accept", in_ready, 0);
        end
        tick();
        in_valid = 1'b0;
        chk("full_queued", exp_q.size(), 16);

        // Full release one cycle after 8th output transfer
        out_ready = 1'b1;
        repeat (7) tick();
        chk("release_early", in_ready, 0);
        tick();
        chk("release_in_ready", in_ready, 1);
        out_ready = 1'b0;
        chk("second_bank_valid", out_valid, 1);
        chk("second_bank_data", out_data, 9);
        drain(1'b0, cyc);

        // Concurrent random streaming, 20 vectors
        base_out  = out_cnt;
        base_last = last_cnt;
        prod_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20 * VL; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    if (i % 3 == 0) send(tbl[(i / 3) % 8]);
                    else send(elem_t'(i * 97 - 5000));
                end
                prod_done = 1'b1;
            end
            begin
                for (int n = 0; n < 5000; n++) begin
                    if (prod_done && exp_q.size() == 0) break;
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                out_ready = 1'b0;
            end
        join
        chk("stream_done", int'(prod_done), 1);
        chk("stream_left", exp_q.size(), 0);
        chk("stream_count", out_cnt - base_out, 20 * VL);
        chk("stream_lasts", last_cnt - base_last, 20);

        // Reset mid-operation
        for (int i = 1; i <= 8; i++) send(elem_t'(i));
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(elem_t'(20 + i));
        reset = 1'b1;
        repeat (2) tick();
        chk("midrst_in_ready", in_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready_rel", in_ready, 1);
        tick();
        for (int i = 100; i <= 107; i++) send(elem_t'(i));
        chk("fresh_valid", out_valid, 1);
        chk("fresh_first", out_data, 100);
        drain(1'b0, cyc);
        chk("fresh_drain_cycles", cyc, 8);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
